// File: rtl/p4_router_pkg.sv
// Shared definitions for the P4 router datapath blocks.
//   TUSER_BAD_FRAME : tuser bit that flags a truncated (bad) frame
//   arb_state_t     : ingress arbiter state encoding
//   max_beats()     : beats needed to carry an MTU-sized frame
package p4_router_pkg;

   localparam int TUSER_BAD_FRAME = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   function automatic int max_beats(input int mtu_bytes, input int data_bytes);
      return (mtu_bytes + data_bytes - 1) / data_bytes;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set bit of req at or
// after ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : starting index of the search
//   grant : one-hot of the winner (zero when no request)
//   idx   : binary index of the winner
//   valid : at least one request present
module rr_priority_pick #(
   parameter int  N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int          p;
      logic [IW-1:0] pi;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      p     = 0;
      pi    = '0;
      for (int k = 0; k < N; k++) begin
         p  = (int'(ptr) + k) % N;
         pi = IW'(p);
         if (!valid && req[pi]) begin
            valid     = 1'b1;
            grant[pi] = 1'b1;
            idx       = pi;
         end
      end
   end

endmodule

// File: rtl/p4_router_ingress_arbiter.sv
// Frame-atomic round-robin merge of the per-port ingress streams onto the
// converged bus. Each output beat carries its source port in tid; frames
// longer than the MTU are cut at the last allowed beat, flagged bad in
// tuser and the rest of the frame is swallowed.
//
// Ports:
//   clk, areset                 clock, async active-high reset
//   ing_t*  [NUM_PORTS]         ingress AXIS slaves (valid/ready/data/keep/last/user)
//   arb_t*                      merged AXIS master (tid = source port)
//   port_enable                 arbitration eligibility, sampled in IDLE only
//   cnts_clear                  per-port statistics clear strobe
//   frame_cnt, oversize_cnt     saturating per-port statistics
//   busy                        arbiter is not in IDLE
//
// state | meaning
// IDLE  | choose next port from (tvalid & port_enable) starting at rr_ptr
// PASS  | forward granted port's beats through the skid register
// DRAIN | oversize tail: granted port always ready, beats discarded
module p4_router_ingress_arbiter
   import p4_router_pkg::*;
#(
   parameter int  NUM_PORTS  = 4,
   parameter int  DATA_BYTES = 64,
   parameter int  MTU_BYTES  = 1500,
   parameter int  CNT_WIDTH  = 32,
   parameter int  USER_WIDTH = 1,
   localparam int DW  = DATA_BYTES * 8,
   localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                                   clk,
   input  logic                                   areset,
   input  logic [NUM_PORTS-1:0]                   ing_tvalid,
   output logic [NUM_PORTS-1:0]                   ing_tready,
   input  logic [NUM_PORTS-1:0][DW-1:0]           ing_tdata,
   input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]   ing_tkeep,
   input  logic [NUM_PORTS-1:0]                   ing_tlast,
   input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]   ing_tuser,
   output logic                                   arb_tvalid,
   input  logic                                   arb_tready,
   output logic [DW-1:0]                          arb_tdata,
   output logic [DATA_BYTES-1:0]                  arb_tkeep,
   output logic                                   arb_tlast,
   output logic [USER_WIDTH-1:0]                  arb_tuser,
   output logic [IDW-1:0]                         arb_tid,
   input  logic [NUM_PORTS-1:0]                   port_enable,
   input  logic [NUM_PORTS-1:0]                   cnts_clear,
   output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]    frame_cnt,
   output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]    oversize_cnt,
   output logic                                   busy
);

   localparam int MAX_BEATS = max_beats(MTU_BYTES, DATA_BYTES);
   localparam int BCW       = $clog2(MAX_BEATS + 1);
   localparam int PW        = DW + DATA_BYTES + 1 + USER_WIDTH + IDW;

   arb_state_t             state;
   logic [IDW-1:0]         grant;
   logic [NUM_PORTS-1:0]   grant_oh;
   logic [IDW-1:0]         rr_ptr;
   logic [IDW-1:0]         next_ptr;
   logic [BCW-1:0]         beat_cnt;

   logic [NUM_PORTS-1:0]   req;
   logic [NUM_PORTS-1:0]   pick_oh;
   logic [IDW-1:0]         pick_idx;
   logic                   pick_any;

   logic                   skid_valid;
   logic [PW-1:0]          skid_word;
   logic [PW-1:0]          out_word;
   logic [PW-1:0]          in_word;
   logic [USER_WIDTH-1:0]  in_user;
   logic                   g_valid;
   logic                   g_last;
   logic                   in_take;
   logic                   drain_take;
   logic                   trunc;
   logic                   frame_end;

   assign req = ing_tvalid & port_enable;

   rr_priority_pick #(.N(NUM_PORTS)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick_oh),
      .idx   (pick_idx),
      .valid (pick_any)
   );

   assign g_valid    = ing_tvalid[grant];
   assign g_last     = ing_tlast[grant];
   // Skid register ready is registered (skid slot empty), so tready never
   // depends combinationally on arb_tready.
   assign in_take    = (state == PASS) && g_valid && !skid_valid;
   assign drain_take = (state == DRAIN) && g_valid;
   assign trunc      = in_take && !g_last && (beat_cnt == BCW'(MAX_BEATS - 1));
   assign frame_end  = in_take && (g_last || trunc);
   assign next_ptr   = (grant == IDW'(NUM_PORTS - 1)) ? '0 : grant + IDW'(1);

   always_comb begin
      in_user                  = ing_tuser[grant];
      in_user[TUSER_BAD_FRAME] = ing_tuser[grant][TUSER_BAD_FRAME] | trunc;
   end

   assign in_word = {ing_tdata[grant], ing_tkeep[grant], g_last | trunc, in_user, grant};
   assign {arb_tdata, arb_tkeep, arb_tlast, arb_tuser, arb_tid} = out_word;

   always_comb begin
      case (state)
         PASS:    ing_tready = grant_oh & {NUM_PORTS{~skid_valid}};
         DRAIN:   ing_tready = grant_oh;
         default: ing_tready = '0;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         grant    <= '0;
         grant_oh <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant    <= pick_idx;
                  grant_oh <= pick_oh;
                  beat_cnt <= '0;
                  state    <= PASS;
                  busy     <= 1'b1;
               end
            end
            PASS: begin
               if (in_take) begin
                  beat_cnt <= beat_cnt + BCW'(1);
                  if (g_last) begin
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                     busy   <= 1'b0;
                  end else if (trunc) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_take && g_last) begin
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Two-entry output register: out_word is the presented beat, skid_word
   // catches the beat accepted in the cycle the consumer stalls.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         arb_tvalid <= 1'b0;
         skid_valid <= 1'b0;
         out_word   <= '0;
         skid_word  <= '0;
      end else if (!arb_tvalid || arb_tready) begin
         if (skid_valid) begin
            out_word   <= skid_word;
            arb_tvalid <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            arb_tvalid <= in_take;
            if (in_take) out_word <= in_word;
         end
      end else if (in_take) begin
         skid_word  <= in_word;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         frame_cnt    <= '0;
         oversize_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (cnts_clear[i]) begin
               frame_cnt[i]    <= '0;
               oversize_cnt[i] <= '0;
            end else begin
               if (frame_end && grant_oh[i] && (frame_cnt[i] != '1))
                  frame_cnt[i] <= frame_cnt[i] + 1'b1;
               if (trunc && grant_oh[i] && (oversize_cnt[i] != '1))
                  oversize_cnt[i] <= oversize_cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
// Bench for p4_router_ingress_arbiter: per-port beat queues feed the
// ingress streams, expected output beats go into a scoreboard queue, and a
// monitor pops and compares every beat taken from the merged stream.
module tb_p4_router_ingress_arbiter;

   localparam int NP   = 4;
   localparam int DB   = 64;
   localparam int DW   = DB * 8;
   localparam int MTU  = 256;
   localparam int CW   = 4;
   localparam int MAXB = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [DB-1:0] keep;
      logic          last;
      logic          bad;
      logic [1:0]    tid;
   } beat_t;

   logic                     clk = 1'b0;
   logic                     areset;
   logic [NP-1:0]            ing_tvalid;
   logic [NP-1:0]            ing_tready;
   logic [NP-1:0][DW-1:0]    ing_tdata;
   logic [NP-1:0][DB-1:0]    ing_tkeep;
   logic [NP-1:0]            ing_tlast;
   logic [NP-1:0][0:0]       ing_tuser;
   logic                     arb_tvalid;
   logic                     arb_tready;
   logic [DW-1:0]            arb_tdata;
   logic [DB-1:0]            arb_tkeep;
   logic                     arb_tlast;
   logic [0:0]               arb_tuser;
   logic [1:0]               arb_tid;
   logic [NP-1:0]            port_enable;
   logic [NP-1:0]            cnts_clear;
   logic [NP-1:0][CW-1:0]    frame_cnt;
   logic [NP-1:0][CW-1:0]    oversize_cnt;
   logic                     busy;

   int            tests = 0;
   int            fails = 0;
   int            cyc   = 0;
   int            acc_cnt [NP];
   logic [NP-1:0] rdy_s;
   bit            rand_mode = 1'b0;
   beat_t         vq [NP][$];
   beat_t         sb [$];
   int            out_cyc [$];

   p4_router_ingress_arbiter #(
      .NUM_PORTS(NP), .DATA_BYTES(DB), .MTU_BYTES(MTU), .CNT_WIDTH(CW), .USER_WIDTH(1)
   ) dut (
      .clk(clk), .areset(areset),
      .ing_tvalid(ing_tvalid), .ing_tready(ing_tready), .ing_tdata(ing_tdata),
      .ing_tkeep(ing_tkeep), .ing_tlast(ing_tlast), .ing_tuser(ing_tuser),
      .arb_tvalid(arb_tvalid), .arb_tready(arb_tready), .arb_tdata(arb_tdata),
      .arb_tkeep(arb_tkeep), .arb_tlast(arb_tlast), .arb_tuser(arb_tuser), .arb_tid(arb_tid),
      .port_enable(port_enable), .cnts_clear(cnts_clear),
      .frame_cnt(frame_cnt), .oversize_cnt(oversize_cnt), .busy(busy)
   );

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mk_data(input int p, input int f, input int b);
      logic [31:0] w;
      w = {8'(p), 8'(f), 8'(b), 8'h5A};
      return {16{w}};
   endfunction

   function automatic logic [DB-1:0] mk_keep(input int b, input int n);
      logic [DB-1:0] k;
      k = '1;
      if (b == n - 1) k = 64'h0000_FFFF_FFFF_FFFF;
      return k;
   endfunction

   task automatic stim_frame(input int p, input int f, input int n);
      beat_t x;
      for (int b = 0; b < n; b++) begin
         x.data = mk_data(p, f, b);
         x.keep = mk_keep(b, n);
         x.last = (b == n - 1);
         x.bad  = 1'b0;
         x.tid  = 2'(p);
         vq[p].push_back(x);
      end
   endtask

   // Hand-derived output: at most MAXB beats; the MAXB-th beat of a longer
   // frame is forced last and flagged bad.
   task automatic expect_frame(input int p, input int f, input int n);
      beat_t x;
      for (int b = 0; b < n && b < MAXB; b++) begin
         x.data = mk_data(p, f, b);
         x.keep = mk_keep(b, n);
         x.last = (b == n - 1) || (b == MAXB - 1);
         x.bad  = (b == MAXB - 1) && (n > MAXB);
         x.tid  = 2'(p);
         sb.push_back(x);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk);
         #3;
         n++;
         done = (sb.size() == 0) && (ing_tvalid == '0) && !arb_tvalid && !busy;
         for (int p = 0; p < NP; p++) if (vq[p].size() != 0) done = 1'b0;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL %s: timeout with %0d expected beats pending, required 0", name, sb.size());
      end
   endtask

   // Ingress drivers and output ready generator, all stepped at negedge.
   initial begin
      beat_t b;
      ing_tvalid = '0;
      ing_tdata  = '0;
      ing_tkeep  = '0;
      ing_tlast  = '0;
      ing_tuser  = '0;
      arb_tready = 1'b0;
      rdy_s      = '0;
      for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            if (ing_tvalid[p] && rdy_s[p]) begin
               ing_tvalid[p] = 1'b0;
               acc_cnt[p]++;
            end
            if (!ing_tvalid[p] && vq[p].size() != 0) begin
               b = vq[p].pop_front();
               ing_tdata[p]  = b.data;
               ing_tkeep[p]  = b.keep;
               ing_tlast[p]  = b.last;
               ing_tvalid[p] = 1'b1;
            end
         end
         arb_tready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
         rdy_s = ing_tready;
      end
   end

   // Monitor: pops the scoreboard on every accepted output beat and checks
   // that a stalled beat is held unchanged.
   initial begin
      beat_t exp;
      bit    stalled;
      logic [DW+DB+3:0] held;
      logic [DW+DB+3:0] cur;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         #1;
         cur = {arb_tdata, arb_tkeep, arb_tlast, arb_tuser, arb_tid};
         if (areset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               tests++;
               if (!arb_tvalid || cur !== held) begin
                  fails++;
                  $display("FAIL stall_hold: tvalid %0b tid %0d data %08h, required held tid %0d data %08h",
                           arb_tvalid, arb_tid, arb_tdata[31:0], held[1:0], held[DW+DB+3-:32]);
               end
            end
            if (arb_tvalid && arb_tready) begin
               stalled = 1'b0;
               out_cyc.push_back(cyc);
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_beat: got tid %0d data %08h, required no beat", arb_tid, arb_tdata[31:0]);
               end else begin
                  exp = sb.pop_front();
                  if (arb_tdata !== exp.data || arb_tkeep !== exp.keep || arb_tlast !== exp.last ||
                      arb_tuser[0] !== exp.bad || arb_tid !== exp.tid) begin
                     fails++;
                     $display("FAIL beat: got tid %0d last %0b bad %0b data %08h keep %016h, required tid %0d last %0b bad %0b data %08h keep %016h",
                              arb_tid, arb_tlast, arb_tuser[0], arb_tdata[31:0], arb_tkeep,
                              exp.tid, exp.last, exp.bad, exp.data[31:0], exp.keep);
                  end
               end
            end else if (arb_tvalid) begin
               stalled = 1'b1;
               held    = cur;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      int base;
      int rdy0_hits;
      int vld_hits;
      bit hit;
      areset      = 1'b1;
      port_enable = '1;
      cnts_clear  = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_tvalid", 64'(arb_tvalid), 64'd0);
      chk("rst_tready", 64'(ing_tready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_oversize_cnt", 64'(oversize_cnt), 64'd0);
      areset = 1'b0;

      // Four simultaneous 3-beat frames leave in port order with one idle
      // cycle between frames.
      out_cyc.delete();
      for (int p = 0; p < NP; p++) begin
         stim_frame(p, 16 + p, 3);
         expect_frame(p, 16 + p, 3);
      end
      wait_idle(200, "t1_done");
      chk("t1_beats", 64'(out_cyc.size()), 64'd12);
      for (int i = 1; i < out_cyc.size(); i++)
         chk("t1_spacing", 64'(out_cyc[i] - out_cyc[i-1]), (i % 3 == 0) ? 64'd2 : 64'd1);
      chk("t1_frame_cnt", 64'(frame_cnt), 64'h1111);

      // Five back-to-back single-beat frames on port 2: one every 2 cycles.
      out_cyc.delete();
      for (int f = 0; f < 5; f++) begin
         stim_frame(2, 32 + f, 1);
         expect_frame(2, 32 + f, 1);
      end
      wait_idle(200, "t2_done");
      chk("t2_beats", 64'(out_cyc.size()), 64'd5);
      for (int i = 1; i < out_cyc.size(); i++)
         chk("t2_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
      chk("t2_frame_cnt", 64'(frame_cnt), 64'h1611);

      // 10-beat frame on port 1 is cut to 4 beats, tail drained; the next
      // frame from the same port passes intact.
      out_cyc.delete();
      base = acc_cnt[1];
      stim_frame(1, 48, 10);
      expect_frame(1, 48, 10);
      stim_frame(1, 49, 3);
      expect_frame(1, 49, 3);
      wait_idle(300, "t3_done");
      chk("t3_out_beats", 64'(out_cyc.size()), 64'd7);
      chk("t3_in_beats_taken", 64'(acc_cnt[1] - base), 64'd13);
      chk("t3_oversize_cnt", 64'(oversize_cnt), 64'h0010);
      chk("t3_frame_cnt", 64'(frame_cnt), 64'h1631);

      // Disabled port 0 holds valid but is never served until enabled.
      port_enable = 4'b1110;
      stim_frame(0, 64, 3);
      rdy0_hits = 0;
      vld_hits  = 0;
      repeat (8) begin
         @(negedge clk);
         #3;
         if (ing_tready[0]) rdy0_hits++;
         if (arb_tvalid) vld_hits++;
      end
      chk("t4_disabled_tready", 64'(rdy0_hits), 64'd0);
      chk("t4_disabled_output", 64'(vld_hits), 64'd0);
      stim_frame(3, 65, 4);
      expect_frame(3, 65, 4);
      expect_frame(0, 64, 3);
      rdy0_hits = 0;
      repeat (3) begin
         @(negedge clk);
         #3;
         if (ing_tready[0]) rdy0_hits++;
      end
      chk("t4_disabled_tready_mid", 64'(rdy0_hits), 64'd0);
      port_enable = '1;
      wait_idle(200, "t4_done");
      chk("t4_frame_cnt", 64'(frame_cnt), 64'h2632);

      // Two-port contention with 30% output ready.
      rand_mode = 1'b1;
      stim_frame(1, 80, 2);
      stim_frame(1, 81, 4);
      stim_frame(1, 82, 1);
      stim_frame(2, 90, 3);
      stim_frame(2, 91, 1);
      stim_frame(2, 92, 4);
      expect_frame(1, 80, 2);
      expect_frame(2, 90, 3);
      expect_frame(1, 81, 4);
      expect_frame(2, 91, 1);
      expect_frame(1, 82, 1);
      expect_frame(2, 92, 4);
      wait_idle(1000, "t5_done");
      rand_mode = 1'b0;
      chk("t5_frame_cnt", 64'(frame_cnt), 64'h2962);

      // Reset on beat 2 of a port-3 frame.
      base = acc_cnt[3];
      stim_frame(3, 100, 4);
      expect_frame(3, 100, 4);
      hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
         @(negedge clk);
         #2;
         if (acc_cnt[3] >= base + 2) hit = 1'b1;
      end
      chk("t6_reached_beat2", 64'(hit), 64'd1);
      areset = 1'b1;
      for (int p = 0; p < NP; p++) vq[p].delete();
      ing_tvalid = '0;
      rdy_s      = '0;
      sb.delete();
      #1;
      chk("t6_rst_tvalid", 64'(arb_tvalid), 64'd0);
      chk("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("t6_rst_oversize_cnt", 64'(oversize_cnt), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("t6_rst_tready", 64'(ing_tready), 64'd0);
      #1;
      areset = 1'b0;
      stim_frame(3, 110, 2);
      stim_frame(0, 111, 2);
      expect_frame(0, 111, 2);
      expect_frame(3, 110, 2);
      wait_idle(200, "t6_done");
      chk("t6_frame_cnt", 64'(frame_cnt), 64'h1001);

      // Saturation of frame_cnt[3], then clear coinciding with a tlast.
      for (int f = 0; f < 14; f++) begin
         stim_frame(3, 120 + f, 1);
         expect_frame(3, 120 + f, 1);
      end
      wait_idle(300, "t7_fill");
      chk("t7_at_max", 64'(frame_cnt), 64'hF001);
      stim_frame(3, 140, 1);
      expect_frame(3, 140, 1);
      wait_idle(100, "t7_sat");
      chk("t7_saturated", 64'(frame_cnt), 64'hF001);
      stim_frame(3, 141, 1);
      expect_frame(3, 141, 1);
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge clk);
         #2;
         if (ing_tvalid[3] && ing_tready[3]) begin
            hit        = 1'b1;
            cnts_clear = 4'b1000;
         end
      end
      chk("t7_clear_aligned", 64'(hit), 64'd1);
      @(negedge clk);
      #2;
      cnts_clear = '0;
      chk("t7_clear_wins", 64'(frame_cnt), 64'h0001);
      chk("t7_clear_oversize", 64'(oversize_cnt), 64'h0000);
      wait_idle(100, "t7_done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
